// File: rtl/pll_mode_switch.sv
// Run-time retuning sequencer for a reconfigurable PLL: writes N, M and C counters
// of a preset mode through the reconfig controller's Avalon-MM port, then qualifies lock.
module pll_mode_switch #(
   parameter int NUM_CH       = 4,
   parameter int NUM_MODES    = 2,
   parameter logic [NUM_MODES*(2+NUM_CH)*18-1:0] MODE_TABLE = '0,
   parameter int LOCK_STABLE  = 16,
   parameter int LOCK_TIMEOUT = 65535,
   localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req,
   input  logic [MW-1:0] req_mode,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [MW-1:0] cur_mode,
   output logic          lock_lost,
   output logic [5:0]    mgmt_address,
   output logic          mgmt_write,
   output logic [31:0]   mgmt_writedata,
   input  logic          mgmt_waitrequest,
   input  logic          pll_locked,
   output logic [2:0]    dbg_state
);

   localparam int SW    = $clog2(LOCK_STABLE + 1);
   localparam int TW    = $clog2(LOCK_TIMEOUT + 1);
   localparam int TBL_W = NUM_MODES * (2 + NUM_CH) * 18;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WR_MODE   = 3'd1,
      WR_N      = 3'd2,
      WR_M      = 3'd3,
      WR_C      = 3'd4,
      WR_START  = 3'd5,
      WAIT_LOCK = 3'd6
   } state_t;

   state_t        state;
   logic          lock_meta;
   logic          lock_s;
   logic          cur_valid;
   logic          pend_v;
   logic [MW-1:0] pend_mode;
   logic [MW-1:0] tgt_mode;
   logic [MW-1:0] in_mode;
   logic [4:0]    ch;
   logic [SW-1:0] stab_cnt;
   logic [TW-1:0] to_cnt;
   logic [5:0]    bus_addr;
   logic [31:0]   bus_data;

   // Mode record layout: {C[NUM_CH-1]..C[0], M, N}, 18 bits per field, mode 0 lowest.
   function automatic logic [17:0] field(input logic [MW-1:0] m, input int f);
      logic [TBL_W-1:0] sh;
      sh = MODE_TABLE >> ((int'(m) * (2 + NUM_CH) + f) * 18);
      return sh[17:0];
   endfunction

   assign in_mode   = req ? req_mode : pend_mode;
   assign dbg_state = state;

   always_comb begin
      bus_addr = '0;
      bus_data = '0;
      case (state)
         WR_N: begin
            bus_addr = 6'd3;
            bus_data = {14'd0, field(tgt_mode, 0)};
         end
         WR_M: begin
            bus_addr = 6'd4;
            bus_data = {14'd0, field(tgt_mode, 1)};
         end
         WR_C: begin
            bus_addr = 6'd5;
            bus_data = {9'd0, ch, field(tgt_mode, 2 + int'(ch))};
         end
         WR_START: begin
            bus_addr = 6'd2;
            bus_data = 32'd1;
         end
         default: ;
      endcase
   end

   // Write handshake: mgmt_write rises with address/data and all three hold until a
   // cycle where mgmt_waitrequest is low; that cycle is the transfer, and mgmt_write is
   // low the following cycle (the next state loads its word in that gap cycle).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         lock_meta      <= 1'b0;
         lock_s         <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
         lock_lost      <= 1'b0;
         cur_mode       <= '0;
         cur_valid      <= 1'b0;
         pend_v         <= 1'b0;
         pend_mode      <= '0;
         tgt_mode       <= '0;
         ch             <= '0;
         stab_cnt       <= '0;
         to_cnt         <= '0;
         mgmt_write     <= 1'b0;
         mgmt_address   <= '0;
         mgmt_writedata <= '0;
      end else begin
         lock_meta <= pll_locked;
         lock_s    <= lock_meta;
         done      <= 1'b0;

         if (state != IDLE && req) begin
            pend_v    <= 1'b1;
            pend_mode <= req_mode;
         end

         case (state)
            IDLE: begin
               if (cur_valid && !lock_s)
                  lock_lost <= 1'b1;
               // A request arriving alongside done waits one cycle in the pending slot.
               if (done) begin
                  if (req) begin
                     pend_v    <= 1'b1;
                     pend_mode <= req_mode;
                  end
               end else if (req || pend_v) begin
                  pend_v <= 1'b0;
                  if (int'(in_mode) >= NUM_MODES) begin
                     err  <= 1'b1;
                     done <= 1'b1;
                  end else if (in_mode == cur_mode && cur_valid && lock_s) begin
                     err       <= 1'b0;
                     lock_lost <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     tgt_mode       <= in_mode;
                     err            <= 1'b0;
                     lock_lost      <= 1'b0;
                     busy           <= 1'b1;
                     state          <= WR_MODE;
                     mgmt_write     <= 1'b1;
                     mgmt_address   <= 6'd0;
                     mgmt_writedata <= 32'd0;
                  end
               end
            end

            WAIT_LOCK: begin
               to_cnt <= to_cnt + TW'(1);
               if (lock_s)
                  stab_cnt <= stab_cnt + SW'(1);
               else
                  stab_cnt <= '0;
               if (lock_s && stab_cnt == SW'(LOCK_STABLE - 1)) begin
                  cur_mode  <= tgt_mode;
                  cur_valid <= 1'b1;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else if (to_cnt == TW'(LOCK_TIMEOUT - 1)) begin
                  err       <= 1'b1;
                  cur_valid <= 1'b0;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               if (!mgmt_write) begin
                  mgmt_write     <= 1'b1;
                  mgmt_address   <= bus_addr;
                  mgmt_writedata <= bus_data;
               end else if (!mgmt_waitrequest) begin
                  mgmt_write <= 1'b0;
                  case (state)
                     WR_MODE: state <= WR_N;
                     WR_N:    state <= WR_M;
                     WR_M: begin
                        state <= WR_C;
                        ch    <= '0;
                     end
                     WR_C: begin
                        if (ch == 5'(NUM_CH - 1))
                           state <= WR_START;
                        else
                           ch <= ch + 5'd1;
                     end
                     default: begin
                        state    <= WAIT_LOCK;
                        stab_cnt <= '0;
                        to_cnt   <= '0;
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_mode_switch.sv
// Directed bench for pll_mode_switch: two-channel, three-mode table, short lock windows;
// a negedge bus monitor checks every write against a queue of hand-computed words.
module tb_pll_mode_switch;

   localparam int NUM_CH       = 2;
   localparam int NUM_MODES    = 3;
   localparam int LOCK_STABLE  = 4;
   localparam int LOCK_TIMEOUT = 100;
   localparam logic [2:0] S_WAIT_LOCK = 3'd6;

   // mode2 {C1,C0,M,N}, mode1 {C1,C0,M,N}, mode0 {C1,C0,M,N}
   localparam logic [215:0] TABLE = {
      18'h00b0b, 18'h00909, 18'h00808, 18'h00707,
      18'h00606, 18'h00505, 18'h00a0a, 18'h10201,
      18'h20303, 18'h00202, 18'h00404, 18'h00101
   };

   logic        clk;
   logic        rst_n;
   logic        req;
   logic [1:0]  req_mode;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  cur_mode;
   logic        lock_lost;
   logic [5:0]  mgmt_address;
   logic        mgmt_write;
   logic [31:0] mgmt_writedata;
   logic        mgmt_waitrequest;
   logic        pll_locked;
   logic [2:0]  dbg_state;

   int n_cmp = 0;
   int n_bad = 0;
   int wr_count = 0;
   logic [37:0] exp_q[$];

   pll_mode_switch #(
      .NUM_CH(NUM_CH), .NUM_MODES(NUM_MODES), .MODE_TABLE(TABLE),
      .LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_mode(req_mode),
      .busy(busy), .done(done), .err(err), .cur_mode(cur_mode),
      .lock_lost(lock_lost), .mgmt_address(mgmt_address),
      .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata),
      .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked),
      .dbg_state(dbg_state)
   );

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_w(input logic [5:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic push_mode(input int m);
      push_w(6'd0, 32'd0);
      if (m == 0) begin
         push_w(6'd3, 32'h0000_0101);
         push_w(6'd4, 32'h0000_0404);
         push_w(6'd5, 32'h0000_0202);
         push_w(6'd5, 32'h0006_0303);
      end else begin
         push_w(6'd3, 32'h0001_0201);
         push_w(6'd4, 32'h0000_0a0a);
         push_w(6'd5, 32'h0000_0505);
         push_w(6'd5, 32'h0004_0606);
      end
      push_w(6'd2, 32'd1);
   endtask

   task automatic drive_req(input logic [1:0] m);
      @(posedge clk); #1;
      req      = 1'b1;
      req_mode = m;
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (dbg_state !== s && n < budget);
      if (dbg_state !== s) check("wait_state", 64'(dbg_state), 64'(s));
   endtask

   task automatic wait_done(input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done !== 1'b1 && n < budget);
      if (done !== 1'b1) check("wait_done", 64'(done), 64'd1);
   endtask

   // scoreboard: every completed transfer must match the queue head, and the next
   // cycle must have mgmt_write low
   logic prev_xfer = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_xfer = 1'b0;
      end else begin
         if (prev_xfer) check("write_gap", 64'(mgmt_write), 64'd0);
         prev_xfer = mgmt_write && !mgmt_waitrequest;
         if (prev_xfer) begin
            wr_count++;
            check("write_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0)
               check("write_word", 64'({mgmt_address, mgmt_writedata}), 64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      int n;
      rst_n = 1'b0; req = 1'b0; req_mode = 2'd0;
      mgmt_waitrequest = 1'b0; pll_locked = 1'b0;

      // reset held with req toggling
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         req = ~req;
         req_mode = 2'd1;
         @(negedge clk);
         check("rst_outs", 64'({busy, done, err, lock_lost, cur_mode, mgmt_write,
                                mgmt_address, mgmt_writedata}), 64'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1; req = 1'b0;
      @(negedge clk);
      check("post_rst_outs", 64'({busy, done, err, lock_lost, cur_mode, mgmt_write,
                                  mgmt_address, mgmt_writedata, dbg_state}), 64'd0);
      repeat (3) @(negedge clk);
      check("post_rst_idle", 64'({busy, mgmt_write}), 64'd0);
      check("post_rst_writes", 64'(wr_count), 64'd0);

      // mode 1, zero-wait bus, lock raised in WAIT_LOCK
      push_mode(1);
      drive_req(2'd1);
      @(posedge clk); #1; req = 1'b0;
      @(negedge clk);
      check("req_to_write", 64'({busy, mgmt_write, mgmt_address}), 64'({1'b1, 1'b1, 6'd0}));
      wait_state(S_WAIT_LOCK, 50, n);
      check("seq_len", 64'(n), 64'd11);
      @(posedge clk); #1; pll_locked = 1'b1;
      @(posedge clk);
      wait_done(30, n);
      check("lock_qual_cycles", 64'(n), 64'(LOCK_STABLE + 2));
      check("mode1_result", 64'({cur_mode, err, busy}), 64'({2'd1, 1'b0, 1'b0}));
      @(negedge clk);
      check("done_pulse", 64'(done), 64'd0);
      check("mode1_writes", 64'(wr_count), 64'd6);

      // same mode while locked: immediate done, no bus traffic
      drive_req(2'd1);
      @(posedge clk); #1; req = 1'b0;
      @(negedge clk);
      check("same_mode_done", 64'({done, busy}), 64'({1'b1, 1'b0}));
      repeat (3) @(negedge clk);
      check("same_mode_no_wr", 64'(wr_count), 64'd6);

      // out-of-range mode
      drive_req(2'd3);
      @(posedge clk); #1; req = 1'b0;
      @(negedge clk);
      check("bad_mode", 64'({done, err, busy, cur_mode}), 64'({1'b1, 1'b1, 1'b0, 2'd1}));

      // lock drop while idle
      @(posedge clk); #1; pll_locked = 1'b0;
      repeat (4) @(negedge clk);
      check("lock_lost", 64'({lock_lost, err}), 64'({1'b1, 1'b1}));

      // mode 0 with a 5-cycle stall on WR_M; mode 2 then mode 1 queued while busy
      push_mode(0);
      push_mode(1);
      drive_req(2'd0);
      @(posedge clk); #1; req = 1'b0;
      @(negedge clk);
      check("accept_clear", 64'({err, lock_lost, busy}), 64'({1'b0, 1'b0, 1'b1}));
      drive_req(2'd2);
      drive_req(2'd1);
      @(posedge clk); #1; req = 1'b0;
      @(posedge clk); #1; mgmt_waitrequest = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("m_hold", 64'({mgmt_write, mgmt_address, mgmt_writedata}),
               64'({1'b1, 6'd4, 32'h0000_0404}));
         @(posedge clk); #1;
         if (i == 4) mgmt_waitrequest = 1'b0;
      end
      @(negedge clk);
      check("m_after_stall", 64'(mgmt_write), 64'd0);
      wait_state(S_WAIT_LOCK, 50, n);
      @(posedge clk); #1; pll_locked = 1'b1;
      wait_done(30, n);
      check("mode0_result", 64'({cur_mode, err}), 64'({2'd0, 1'b0}));
      @(negedge clk);
      check("pend_wait", 64'({busy, mgmt_write}), 64'd0);
      @(negedge clk);
      check("pend_start", 64'({busy, mgmt_write, mgmt_address}), 64'({1'b1, 1'b1, 6'd0}));
      wait_done(60, n);
      check("pend_result", 64'({cur_mode, err}), 64'({2'd1, 1'b0}));
      check("queue_drained_1", 64'(exp_q.size()), 64'd0);

      // lock timeout; a request landing on the done cycle goes through pending
      @(posedge clk); #1; pll_locked = 1'b0;
      repeat (4) @(negedge clk);
      check("lock_lost_2", 64'(lock_lost), 64'd1);
      push_mode(0);
      drive_req(2'd0);
      @(posedge clk); #1; req = 1'b0;
      @(negedge clk);
      check("accept_clear_2", 64'({lock_lost, busy}), 64'({1'b0, 1'b1}));
      wait_state(S_WAIT_LOCK, 50, n);
      check("seq_len_2", 64'(n), 64'd11);
      repeat (97) begin
         @(posedge clk); #1;
      end
      pll_locked = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("timeout_early", 64'(done), 64'd0);
      push_mode(1);
      drive_req(2'd1);
      @(negedge clk);
      check("timeout", 64'({done, err, busy, cur_mode}), 64'({1'b1, 1'b1, 1'b0, 2'd1}));
      @(posedge clk); #1; req = 1'b0;
      @(negedge clk);
      check("to_pend_wait", 64'({busy, mgmt_write}), 64'd0);
      @(negedge clk);
      check("to_pend_start", 64'({busy, mgmt_write, err}), 64'({1'b1, 1'b1, 1'b0}));
      wait_done(60, n);
      check("final_result", 64'({cur_mode, err, lock_lost}), 64'({2'd1, 1'b0, 1'b0}));
      check("queue_drained_2", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
